// File: rtl/except_ctrl_pkg.sv
// Shared exception codes, sequencer states and CP0 field positions for the
// MEM/WB exception controller.
package exc_pkg;

  localparam logic [31:0] EXC_NONE = 32'h0;
  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_ADEL = 32'h4;
  localparam logic [31:0] EXC_ADES = 32'h5;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_BP   = 32'h9;
  localparam logic [31:0] EXC_RI   = 32'hA;
  localparam logic [31:0] EXC_OV   = 32'hC;
  localparam logic [31:0] EXC_TR   = 32'hD;
  localparam logic [31:0] EXC_ERET = 32'hE;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int IM_HI      = 15;
  localparam int IM_LO      = 8;
  localparam int IP_HI      = 15;
  localparam int IP_LO      = 8;

endpackage

// File: rtl/except_ctrl_int_sync.sv
// Two-flop synchronizer for asynchronous level inputs; async active-low reset.
module int_sync #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/except_ctrl.sv
// Exception/interrupt sequencer: reports one prioritized event to cp0_reg,
// then flushes IF..MEM and hands a redirect PC to fetch via ready/valid.
module except_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic        mem_valid_i,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] mem_addr_i,
  input  logic        exc_ri_i,
  input  logic        exc_sys_i,
  input  logic        exc_brk_i,
  input  logic        exc_trap_i,
  input  logic        exc_ov_i,
  input  logic        exc_eret_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic        mem_misalign_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  input  logic        redirect_ready_i,
  output logic [31:0] newpc_o,
  output logic        busy_o
);

  logic [5:0]  int_s;
  logic [7:0]  ip;
  logic        int_pend;
  logic [31:0] exc_code;
  logic [31:0] exc_bad;
  logic        accept;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] newpc_q, newpc_d;
  logic        flush_q, flush_d;
  logic        rv_q, rv_d;
  logic        busy_q, busy_d;

  int_sync #(.WIDTH(6)) u_int_sync (
    .clk   (clk),
    .rst_n (rst),
    .d_i   (int_i),
    .q_o   (int_s)
  );

  assign ip       = {int_s, cause_i[IP_LO+1:IP_LO]};
  assign int_pend = (|(ip & status_i[IM_HI:IM_LO])) & status_i[STATUS_IE] & ~status_i[STATUS_EXL];

  always_comb begin
    exc_code = EXC_NONE;
    exc_bad  = '0;
    if (int_pend)                            exc_code = EXC_INT;
    else if (pc_i[1:0] != 2'b00) begin
      exc_code = EXC_ADEL;
      exc_bad  = pc_i;
    end
    else if (exc_ri_i)                       exc_code = EXC_RI;
    else if (exc_sys_i)                      exc_code = EXC_SYS;
    else if (exc_brk_i)                      exc_code = EXC_BP;
    else if (exc_trap_i)                     exc_code = EXC_TR;
    else if (exc_ov_i)                       exc_code = EXC_OV;
    else if (is_load_i && mem_misalign_i) begin
      exc_code = EXC_ADEL;
      exc_bad  = mem_addr_i;
    end
    else if (is_store_i && mem_misalign_i) begin
      exc_code = EXC_ADES;
      exc_bad  = mem_addr_i;
    end
    else if (exc_eret_i)                     exc_code = EXC_ERET;
  end

  // Gated by rst so cp0_reg never sees a strobe while the block is held in reset.
  assign accept = rst & (state_q == IDLE) & mem_valid_i & ~stall_i & (exc_code != EXC_NONE);

  assign excepttype_o        = accept ? exc_code : EXC_NONE;
  assign current_inst_addr_o = accept ? pc_i : '0;
  assign is_in_delayslot_o   = accept & is_in_delayslot_i;
  assign bad_addr_o          = accept ? exc_bad : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    newpc_d = newpc_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = FLUSH;
          cnt_d   = 4'(FLUSH_CYCLES);
          newpc_d = (exc_code == EXC_ERET) ? epc_i : EXC_VECTOR;
        end
      end
      FLUSH: begin
        if (cnt_q <= 4'd1) begin
          state_d = REDIRECT;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      REDIRECT: begin
        if (redirect_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    flush_d = (state_d == FLUSH);
    rv_d    = (state_d == REDIRECT);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      newpc_q <= '0;
      flush_q <= 1'b0;
      rv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      newpc_q <= newpc_d;
      flush_q <= flush_d;
      rv_q    <= rv_d;
      busy_q  <= busy_d;
    end
  end

  assign flush_o          = flush_q;
  assign redirect_valid_o = rv_q;
  assign newpc_o          = newpc_q;
  assign busy_o           = busy_q;

  logic unused_bits;
  assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[IP_HI:IP_LO+2], cause_i[7:0]};

endmodule

// File: tb/tb_except_ctrl.sv
// Bench for except_ctrl: vector table, directed multi-cycle sequences and
// randomized transactions against a priority-list reference model.
module tb_except_ctrl;

  localparam int FC = 2;
  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic        mem_valid_i, stall_i, is_in_delayslot_i;
  logic [31:0] pc_i, mem_addr_i, status_i, cause_i, epc_i;
  logic        exc_ri_i, exc_sys_i, exc_brk_i, exc_trap_i, exc_ov_i, exc_eret_i;
  logic        is_load_i, is_store_i, mem_misalign_i;
  logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, newpc_o;
  logic        is_in_delayslot_o, flush_o, redirect_valid_o, redirect_ready_i, busy_o;

  int n_chk = 0;
  int n_fail = 0;

  except_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .int_i(int_i), .mem_valid_i(mem_valid_i), .stall_i(stall_i),
    .pc_i(pc_i), .is_in_delayslot_i(is_in_delayslot_i), .mem_addr_i(mem_addr_i),
    .exc_ri_i(exc_ri_i), .exc_sys_i(exc_sys_i), .exc_brk_i(exc_brk_i), .exc_trap_i(exc_trap_i),
    .exc_ov_i(exc_ov_i), .exc_eret_i(exc_eret_i), .is_load_i(is_load_i), .is_store_i(is_store_i),
    .mem_misalign_i(mem_misalign_i), .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
    .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
    .is_in_delayslot_o(is_in_delayslot_o), .bad_addr_o(bad_addr_o), .flush_o(flush_o),
    .redirect_valid_o(redirect_valid_o), .redirect_ready_i(redirect_ready_i),
    .newpc_o(newpc_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // flag order: {ri, sys, brk, trap, ov, eret, load, store, misalign}
  typedef struct {
    logic [31:0] pc, mem_addr, epc, status, cause;
    logic [8:0]  flags;
    logic        ds;
    int          rdel;
    logic [31:0] exp_code, exp_bad, exp_newpc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_valid_i = 0; stall_i = 0; is_in_delayslot_i = 0;
    pc_i = 32'h80000000; mem_addr_i = 0; status_i = 0; cause_i = 0; epc_i = 0;
    {exc_ri_i, exc_sys_i, exc_brk_i, exc_trap_i, exc_ov_i, exc_eret_i,
     is_load_i, is_store_i, mem_misalign_i} = '0;
  endtask

  task automatic drive(input logic [31:0] pc, ma, epc, st, ca, input logic [8:0] f, input logic ds);
    pc_i = pc; mem_addr_i = ma; epc_i = epc; status_i = st; cause_i = ca;
    is_in_delayslot_i = ds; mem_valid_i = 1; stall_i = 0;
    {exc_ri_i, exc_sys_i, exc_brk_i, exc_trap_i, exc_ov_i, exc_eret_i,
     is_load_i, is_store_i, mem_misalign_i} = f;
  endtask

  // Checks the accept-cycle strobe, then the flush window and the redirect handshake.
  task automatic run_seq(input logic [31:0] code, bad, pc, npc, input logic ds,
                         input int rdel, input bit keep);
    chk("excepttype", excepttype_o, code);
    chk("bad_addr", bad_addr_o, bad);
    chk("cur_addr", current_inst_addr_o, (code != 0) ? pc : 32'h0);
    chk("delayslot", {31'b0, is_in_delayslot_o}, {31'b0, (code != 0) & ds});
    step();
    if (!keep) clear_inputs();
    if (code == 0) begin
      chk("busy_no_accept", {31'b0, busy_o}, 32'h0);
      return;
    end
    for (int i = 0; i < FC; i++) begin
      chk("flush_hi", {31'b0, flush_o}, 32'h1);
      chk("rv_in_flush", {31'b0, redirect_valid_o}, 32'h0);
      chk("no_strobe_flush", excepttype_o, 32'h0);
      step();
    end
    for (int d = 0; d <= rdel; d++) begin
      chk("flush_lo", {31'b0, flush_o}, 32'h0);
      chk("rv_hi", {31'b0, redirect_valid_o}, 32'h1);
      chk("newpc", newpc_o, npc);
      chk("no_strobe_redir", excepttype_o, 32'h0);
      if (d == rdel) begin
        if (keep) clear_inputs();
        redirect_ready_i = 1;
      end
      step();
      redirect_ready_i = 0;
    end
    chk("busy_idle", {31'b0, busy_o}, 32'h0);
    chk("rv_idle", {31'b0, redirect_valid_o}, 32'h0);
  endtask

  // Reference: ordered list of (condition, code, bad address); first hit wins.
  task automatic ref_model(input logic [31:0] pc, st, ca, ma, epc, input logic [8:0] f,
                           input logic mv, output logic [31:0] code, bad, npc);
    bit hit[10];
    logic [31:0] c[10];
    logic [31:0] b[10];
    hit[0] = ((ca[9:8] & st[9:8]) != 0) && st[0] && !st[1]; c[0] = 32'h1; b[0] = 0;
    hit[1] = (pc % 4) != 0;          c[1] = 32'h4; b[1] = pc;
    hit[2] = f[8];                   c[2] = 32'hA; b[2] = 0;
    hit[3] = f[7];                   c[3] = 32'h8; b[3] = 0;
    hit[4] = f[6];                   c[4] = 32'h9; b[4] = 0;
    hit[5] = f[5];                   c[5] = 32'hD; b[5] = 0;
    hit[6] = f[4];                   c[6] = 32'hC; b[6] = 0;
    hit[7] = f[2] && f[0];           c[7] = 32'h4; b[7] = ma;
    hit[8] = f[1] && f[0];           c[8] = 32'h5; b[8] = ma;
    hit[9] = f[3];                   c[9] = 32'hE; b[9] = 0;
    code = 0; bad = 0;
    if (mv) begin
      for (int k = 9; k >= 0; k--) if (hit[k]) begin code = c[k]; bad = b[k]; end
    end
    npc = (code == 32'hE) ? epc : VEC;
  endtask

  vec_t tv[12];

  initial begin
    tv[0]  = '{32'h80001000, 0, 0, 32'h10000000, 0, 9'b010000000, 0, 0, 32'h8, 0, VEC};
    tv[1]  = '{32'h80001000, 32'h80002003, 0, 0, 0, 9'b000000101, 0, 1, 32'h4, 32'h80002003, VEC};
    tv[2]  = '{32'h80001002, 32'h80002003, 0, 0, 0, 9'b000000101, 0, 0, 32'h4, 32'h80001002, VEC};
    tv[3]  = '{32'h80001000, 32'h80002001, 0, 0, 0, 9'b000000011, 1, 0, 32'h5, 32'h80002001, VEC};
    tv[4]  = '{32'h80001004, 0, 0, 0, 0, 9'b110010000, 0, 0, 32'hA, 0, VEC};
    tv[5]  = '{32'h80001008, 0, 0, 0, 0, 9'b001100000, 0, 2, 32'h9, 0, VEC};
    tv[6]  = '{32'h8000100C, 0, 0, 0, 0, 9'b000110000, 0, 0, 32'hD, 0, VEC};
    tv[7]  = '{32'h80001010, 0, 32'h80003000, 0, 0, 9'b000011000, 0, 0, 32'hC, 0, VEC};
    tv[8]  = '{32'h80001014, 0, 32'h80003000, 0, 0, 9'b000001000, 0, 5, 32'hE, 0, 32'h80003000};
    tv[9]  = '{32'h80001018, 0, 0, 32'h0000FF01, 32'h100, 9'b010000000, 1, 0, 32'h1, 0, VEC};
    tv[10] = '{32'h8000101C, 0, 0, 32'h0000FF03, 32'h100, 9'b010000000, 0, 0, 32'h8, 0, VEC};
    tv[11] = '{32'h80001020, 32'h80002003, 0, 32'h0000FF01, 0, 9'b000000100, 0, 0, 32'h0, 0, VEC};

    rst = 0; int_i = 0; redirect_ready_i = 0;
    clear_inputs();
    #1;
    chk("rst_newpc", newpc_o, 32'h0);
    chk("rst_flags", {28'b0, flush_o, redirect_valid_o, busy_o, is_in_delayslot_o}, 32'h0);
    chk("rst_strobe", excepttype_o, 32'h0);
    step(); step();
    rst = 1;
    step();

    for (int i = 0; i < 12; i++) begin
      drive(tv[i].pc, tv[i].mem_addr, tv[i].epc, tv[i].status, tv[i].cause, tv[i].flags, tv[i].ds);
      #1;
      run_seq(tv[i].exp_code, tv[i].exp_bad, tv[i].pc, tv[i].exp_newpc, tv[i].ds, tv[i].rdel, 1'b0);
    end

    // Bubble carrying a syscall is ignored.
    drive(32'h80001000, 0, 0, 0, 0, 9'b010000000, 0);
    mem_valid_i = 0;
    #1;
    run_seq(32'h0, 0, 32'h80001000, VEC, 0, 0, 1'b0);

    // Hardware interrupt sees two cycles of synchronizer latency.
    drive(32'h80004000, 0, 0, 32'h0000FF01, 0, 9'b0, 0);
    int_i = 6'b000001;
    #1;
    chk("int_lat0", excepttype_o, 32'h0);
    step();
    chk("int_lat1", excepttype_o, 32'h0);
    step();
    int_i = 0;
    run_seq(32'h1, 0, 32'h80004000, VEC, 0, 0, 1'b0);

    // EXL set masks the interrupt.
    drive(32'h80004000, 0, 0, 32'h0000FF03, 0, 9'b0, 0);
    int_i = 6'b000001;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("exl_mask", excepttype_o, 32'h0);
      chk("exl_busy", {31'b0, busy_o}, 32'h0);
    end
    int_i = 0; clear_inputs();
    step(); step(); step();

    // Syscall held through flush and redirect produces only one strobe.
    drive(32'h80005000, 0, 0, 0, 0, 9'b010000000, 0);
    #1;
    run_seq(32'h8, 0, 32'h80005000, VEC, 0, 1, 1'b1);

    // Stall defers an overflow until it drops.
    drive(32'h80005004, 0, 0, 0, 0, 9'b000010000, 0);
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_hold", excepttype_o, 32'h0);
      step();
      chk("stall_busy", {31'b0, busy_o}, 32'h0);
    end
    stall_i = 0;
    #1;
    run_seq(32'hC, 0, 32'h80005004, VEC, 0, 0, 1'b0);

    // Reset asserted mid-REDIRECT abandons the sequence.
    drive(32'h80006000, 0, 0, 0, 0, 9'b010000000, 0);
    step();
    clear_inputs();
    for (int i = 0; i < FC; i++) step();
    chk("pre_rst_rv", {31'b0, redirect_valid_o}, 32'h1);
    drive(32'h80006000, 0, 0, 0, 0, 9'b010000000, 0);
    rst = 0;
    #1;
    chk("rst_mid_newpc", newpc_o, 32'h0);
    chk("rst_mid_flags", {28'b0, flush_o, redirect_valid_o, busy_o, is_in_delayslot_o}, 32'h0);
    chk("rst_mid_strobe", excepttype_o, 32'h0);
    step();
    rst = 1; clear_inputs();
    step();
    chk("post_rst_busy", {31'b0, busy_o}, 32'h0);
    drive(32'h80006008, 0, 0, 0, 0, 9'b001000000, 0);
    #1;
    run_seq(32'h9, 0, 32'h80006008, VEC, 0, 0, 1'b0);

    // Randomized transactions against the reference model.
    for (int t = 0; t < 60; t++) begin
      logic [31:0] pc, ma, epc, st, ca, ecode, ebad, enpc, r;
      logic [8:0]  f;
      logic        mv, ds;
      int          rdel;
      pc = $urandom; r = $urandom;
      if (r[2:0] != 0) pc[1:0] = 2'b00;
      ma = $urandom; epc = $urandom; st = $urandom; ca = $urandom;
      f = 9'($urandom) & 9'($urandom);
      mv = ($urandom_range(0, 9) != 0);
      ds = r[4];
      rdel = $urandom_range(0, 3);
      ref_model(pc, st, ca, ma, epc, f, mv, ecode, ebad, enpc);
      drive(pc, ma, epc, st, ca, f, ds);
      mem_valid_i = mv;
      #1;
      run_seq(ecode, ebad, pc, enpc, ds, rdel, r[5]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
